// File: rtl/axi_test_pkg.sv
// rtl/axi_test_pkg.sv - shared types and pattern function for the meta-AXI4 self-test master
package axi_test_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_AW,
    ST_W,
    ST_B,
    ST_AR,
    ST_R,
    ST_PEND
  } state_e;

  typedef enum logic [1:0] {
    MODE_ADDR,
    MODE_INV,
    MODE_HASH,
    MODE_WALK1
  } mode_e;

  localparam logic [31:0] HASH_MULT = 32'h9E3779B1;

  // 32-bit test word for word address w during pass p
  function automatic logic [31:0] pattern(input logic [31:0] w,
                                          input logic [15:0] p,
                                          input mode_e       mode);
    logic [31:0] f;
    case (mode)
      MODE_ADDR: f = w;
      MODE_INV:  f = ~w;
      MODE_HASH: f = (w * HASH_MULT) ^ {16'b0, p};
      default:   f = 32'h1 << w[4:0];
    endcase
    return f;
  endfunction

endpackage

// File: rtl/axi_test_pattern_gen.sv
// rtl/axi_test_pattern_gen.sv - expands the 32-bit test word across one data beat
import axi_test_pkg::*;

module axi_test_pattern_gen #(
  parameter int D_WIDTH = 16
) (
  input  logic [31:0]        word_i,
  input  logic [15:0]        pass_i,
  input  mode_e              mode_i,
  output logic [D_WIDTH-1:0] data_o
);

  localparam int REPS = (D_WIDTH + 31) / 32;

  logic [32*REPS-1:0] rep;

  // narrow beats keep the low bits; wide beats repeat the word
  assign rep    = {REPS{pattern(word_i, pass_i, mode_i)}};
  assign data_o = rep[D_WIDTH-1:0];

endmodule

// File: rtl/axi_pattern_test_master.sv
// rtl/axi_pattern_test_master.sv - write-then-verify pattern master on the meta-AXI4 port
import axi_test_pkg::*;

module axi_pattern_test_master #(
  parameter int         A_WIDTH      = 25,
  parameter int         A_WIDTH_TEST = 14,
  parameter int         D_WIDTH      = 16,
  parameter int         D_LEVEL      = 1,
  parameter logic [7:0] WBURST_LEN   = 8'd7,
  parameter logic [7:0] RBURST_LEN   = 8'd7,
  parameter int         ECNT_W       = 16
) (
  input  logic               aclk,
  input  logic               aresetn,
  input  logic               start,
  input  logic [1:0]         mode,
  input  logic               loop,
  output logic               awvalid,
  input  logic               awready,
  output logic [A_WIDTH-1:0] awaddr,
  output logic [7:0]         awlen,
  output logic               wvalid,
  input  logic               wready,
  output logic               wlast,
  output logic [D_WIDTH-1:0] wdata,
  input  logic               bvalid,
  output logic               bready,
  output logic               arvalid,
  input  logic               arready,
  output logic [A_WIDTH-1:0] araddr,
  output logic [7:0]         arlen,
  input  logic               rvalid,
  output logic               rready,
  input  logic               rlast,
  input  logic [D_WIDTH-1:0] rdata,
  output logic               busy,
  output logic               done,
  output logic [15:0]        pass_cnt,
  output logic               error,
  output logic [ECNT_W-1:0]  error_cnt,
  output logic [A_WIDTH-1:0] err_addr
);

  localparam int AT    = A_WIDTH_TEST;
  localparam int WSTEP = (int'(WBURST_LEN) + 1) << D_LEVEL;
  localparam int RSTEP = (int'(RBURST_LEN) + 1) << D_LEVEL;
  localparam logic [ECNT_W+1:0] ECNT_MAX = {2'b00, {ECNT_W{1'b1}}};

  state_e             state_q, state_d;
  mode_e              mode_q, mode_d;
  logic [AT-1:0]      base_q, base_d;
  logic [7:0]         beat_q, beat_d;
  logic [15:0]        pass_q, pass_d;
  logic               error_q, error_d;
  logic [ECNT_W-1:0]  ecnt_q, ecnt_d;
  logic [A_WIDTH-1:0] eaddr_q, eaddr_d;

  logic [AT-1:0]      beat_off;
  logic [AT-1:0]      cur_addr;
  logic [31:0]        cur_word;
  logic [AT:0]        wsum, rsum;
  logic [D_WIDTH-1:0] wgen, rexp;
  logic               beat_bad, last_bad;
  logic [1:0]         n_err;
  logic [ECNT_W+1:0]  ecnt_sum;

  // the carry out of the base adder marks the end of the region
  assign beat_off = AT'(beat_q) << D_LEVEL;
  assign cur_addr = base_q + beat_off;
  assign cur_word = 32'(cur_addr >> D_LEVEL);
  assign wsum     = {1'b0, base_q} + (AT+1)'(WSTEP);
  assign rsum     = {1'b0, base_q} + (AT+1)'(RSTEP);

  axi_test_pattern_gen #(.D_WIDTH(D_WIDTH)) u_wr_gen (
    .word_i (cur_word),
    .pass_i (pass_q),
    .mode_i (mode_q),
    .data_o (wgen)
  );

  axi_test_pattern_gen #(.D_WIDTH(D_WIDTH)) u_rd_gen (
    .word_i (cur_word),
    .pass_i (pass_q),
    .mode_i (mode_q),
    .data_o (rexp)
  );

  // a beat can cost two errors: bad data plus a misplaced rlast
  assign beat_bad = (rdata != rexp);
  assign last_bad = (rlast != (beat_q == RBURST_LEN));
  assign n_err    = {1'b0, beat_bad} + {1'b0, last_bad};
  assign ecnt_sum = {2'b00, ecnt_q} + {{ECNT_W{1'b0}}, n_err};

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q <= ST_IDLE;
      mode_q  <= MODE_ADDR;
      base_q  <= '0;
      beat_q  <= '0;
      pass_q  <= '0;
      error_q <= 1'b0;
      ecnt_q  <= '0;
      eaddr_q <= '0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      base_q  <= base_d;
      beat_q  <= beat_d;
      pass_q  <= pass_d;
      error_q <= error_d;
      ecnt_q  <= ecnt_d;
      eaddr_q <= eaddr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    base_d  = base_q;
    beat_d  = beat_q;
    pass_d  = pass_q;
    error_d = error_q;
    ecnt_d  = ecnt_q;
    eaddr_d = eaddr_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_AW;
          mode_d  = mode_e'(mode);
          base_d  = '0;
          beat_d  = '0;
          pass_d  = '0;
          error_d = 1'b0;
          ecnt_d  = '0;
          eaddr_d = '0;
        end
      end
      ST_AW: begin
        if (awready) state_d = ST_W;
      end
      ST_W: begin
        if (wready) begin
          if (beat_q == WBURST_LEN) begin
            beat_d  = '0;
            state_d = ST_B;
          end else begin
            beat_d = beat_q + 8'd1;
          end
        end
      end
      ST_B: begin
        if (bvalid) begin
          base_d  = wsum[AT-1:0];
          state_d = wsum[AT] ? ST_AR : ST_AW;
        end
      end
      ST_AR: begin
        if (arready) state_d = ST_R;
      end
      ST_R: begin
        if (rvalid) begin
          if (n_err != 2'd0) begin
            error_d = 1'b1;
            ecnt_d  = (ecnt_sum > ECNT_MAX) ? {ECNT_W{1'b1}} : ecnt_sum[ECNT_W-1:0];
            if (!error_q) eaddr_d = A_WIDTH'(cur_addr);
          end
          // burst length is fixed; a missing rlast does not stretch it
          if (beat_q == RBURST_LEN) begin
            beat_d  = '0;
            base_d  = rsum[AT-1:0];
            state_d = rsum[AT] ? ST_PEND : ST_AR;
          end else begin
            beat_d = beat_q + 8'd1;
          end
        end
      end
      ST_PEND: begin
        pass_d  = pass_q + 16'd1;
        state_d = loop ? ST_AW : ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign awvalid   = (state_q == ST_AW);
  assign awaddr    = A_WIDTH'(base_q);
  assign awlen     = WBURST_LEN;
  assign wvalid    = (state_q == ST_W);
  assign wlast     = wvalid && (beat_q == WBURST_LEN);
  assign wdata     = wvalid ? wgen : '0;
  assign bready    = (state_q == ST_B);
  assign arvalid   = (state_q == ST_AR);
  assign araddr    = A_WIDTH'(base_q);
  assign arlen     = RBURST_LEN;
  assign rready    = (state_q == ST_R);
  assign busy      = (state_q != ST_IDLE);
  assign done      = (state_q == ST_PEND);
  assign pass_cnt  = pass_q;
  assign error     = error_q;
  assign error_cnt = ecnt_q;
  assign err_addr  = eaddr_q;

endmodule

// File: tb/tb_axi_pattern_test_master.sv
// tb/tb_axi_pattern_test_master.sv - directed bench with an ideal meta-AXI4 slave memory
module tb_axi_pattern_test_master;

  localparam int AW = 25;

  logic          aclk = 1'b0;
  logic          aresetn = 1'b0;
  logic          start = 1'b0;
  logic [1:0]    mode = 2'd0;
  logic          loop = 1'b0;
  logic          awvalid, awready, wvalid, wready, wlast, bvalid, bready;
  logic          arvalid, arready, rvalid, rready, rlast;
  logic [AW-1:0] awaddr, araddr, err_addr;
  logic [7:0]    awlen, arlen;
  logic [15:0]   wdata, rdata, pass_cnt;
  logic          busy, done, error;
  logic [1:0]    error_cnt;

  axi_pattern_test_master #(
    .A_WIDTH(AW), .A_WIDTH_TEST(8), .D_WIDTH(16), .D_LEVEL(1),
    .WBURST_LEN(8'd7), .RBURST_LEN(8'd7), .ECNT_W(2)
  ) dut (
    .aclk(aclk), .aresetn(aresetn), .start(start), .mode(mode), .loop(loop),
    .awvalid(awvalid), .awready(awready), .awaddr(awaddr), .awlen(awlen),
    .wvalid(wvalid), .wready(wready), .wlast(wlast), .wdata(wdata),
    .bvalid(bvalid), .bready(bready),
    .arvalid(arvalid), .arready(arready), .araddr(araddr), .arlen(arlen),
    .rvalid(rvalid), .rready(rready), .rlast(rlast), .rdata(rdata),
    .busy(busy), .done(done), .pass_cnt(pass_cnt), .error(error),
    .error_cnt(error_cnt), .err_addr(err_addr)
  );

  initial forever #5 aclk = ~aclk;

  int corrupt_addr = -1;
  int drop_addr = -1;
  bit invert = 1'b0;
  bit stall = 1'b0;
  logic [7:0]  aw_log[$];
  logic [7:0]  ar_log[$];
  logic [15:0] w0_log[$];
  int wlast_err = 0;
  int stab_err = 0;
  logic [15:0] mem [0:127];

  // slave: handshakes sampled on the falling edge, responses driven just after the rising edge
  initial begin
    bit aw_hs, w_hs, b_hs, ar_hs, r_hs, wl, pw_stall, pa_stall, r_active;
    logic [15:0] wd, pw_d;
    logic [7:0] aa, ra, pa;
    int wptr, wcnt, rptr, rcnt, rbase, idx;
    awready = 0; wready = 0; bvalid = 0; arready = 0; rvalid = 0; rlast = 0; rdata = '0;
    pw_stall = 0; pa_stall = 0; r_active = 0;
    wptr = 0; wcnt = 0; rptr = 0; rcnt = 0; rbase = 0; pw_d = '0; pa = '0;
    for (int i = 0; i < 128; i++) mem[i] = '0;
    forever begin
      @(negedge aclk);
      aw_hs = aresetn && awvalid && awready;
      w_hs  = aresetn && wvalid && wready;
      b_hs  = aresetn && bvalid && bready;
      ar_hs = aresetn && arvalid && arready;
      r_hs  = aresetn && rvalid && rready;
      wd = wdata; wl = wlast; aa = awaddr[7:0]; ra = araddr[7:0];
      if (aresetn && pw_stall && wvalid && wdata !== pw_d) stab_err++;
      if (aresetn && pa_stall && awvalid && awaddr[7:0] !== pa) stab_err++;
      pw_stall = aresetn && wvalid && !wready; pw_d = wdata;
      pa_stall = aresetn && awvalid && !awready; pa = awaddr[7:0];
      @(posedge aclk); #1;
      if (!aresetn) begin
        awready = 0; wready = 0; bvalid = 0; arready = 0; rvalid = 0; rlast = 0; rdata = '0;
        r_active = 0; pw_stall = 0; pa_stall = 0; wcnt = 0; rcnt = 0;
      end else begin
        if (aw_hs) begin wptr = int'(aa) >> 1; wcnt = 0; aw_log.push_back(aa); end
        if (w_hs) begin
          idx = (wptr + wcnt) & 127;
          mem[idx] = wd;
          if (idx == 0) w0_log.push_back(wd);
          if (wl != (wcnt == 7)) wlast_err++;
          wcnt++;
          if (wcnt == 8) bvalid = 1;
        end
        if (b_hs) bvalid = 0;
        if (ar_hs) begin rptr = int'(ra) >> 1; rbase = int'(ra); rcnt = 0; r_active = 1; ar_log.push_back(ra); end
        if (r_hs) begin rcnt++; if (rcnt == 8) r_active = 0; end
        awready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
        wready  = stall ? 1'($urandom_range(0, 1)) : 1'b1;
        arready = 1'b1;
        rvalid  = r_active && (stall ? 1'($urandom_range(0, 1)) : 1'b1);
        idx = (rptr + rcnt) & 127;
        rdata = r_active ? mem[idx] : '0;
        if (invert) rdata = ~rdata;
        if (r_active && (rbase + 2 * rcnt) == corrupt_addr) rdata = rdata ^ 16'h0100;
        rlast = r_active && (rcnt == 7) && (rbase != drop_addr);
      end
    end
  end

  int n_cmp = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic wait_done(input string name, output bit ok);
    ok = 0;
    for (int c = 0; c < 6000; c++) begin
      @(negedge aclk);
      if (done) begin ok = 1; break; end
    end
    if (!ok) begin
      n_cmp++; n_fail++;
      $display("FAIL %s: done not seen within 6000 cycles", name);
    end
  endtask

  typedef struct {
    string name;
    logic [1:0] mode;
    int passes;
    int corrupt;
    int drop;
    bit invert;
    bit stall;
    bit exp_err;
    int exp_ecnt;
    int exp_eaddr;
    int exp_pcnt;
  } vec_t;

  vec_t vecs[6];

  task automatic run_vec(input vec_t v);
    bit ok;
    corrupt_addr = v.corrupt; drop_addr = v.drop; invert = v.invert; stall = v.stall;
    aw_log.delete(); ar_log.delete(); w0_log.delete(); wlast_err = 0; stab_err = 0;
    @(posedge aclk); #1;
    start = 1; mode = v.mode; loop = (v.passes > 1);
    @(negedge aclk);
    chk({v.name, " awvalid before start edge"}, 32'(awvalid), 0);
    @(posedge aclk); #1;
    start = 0;
    @(negedge aclk);
    chk({v.name, " awvalid after start"}, 32'(awvalid), 1);
    chk({v.name, " busy after start"}, 32'(busy), 1);
    for (int p = 1; p <= v.passes; p++) begin
      wait_done(v.name, ok);
      if (!ok) return;
      if (p == v.passes - 1) begin @(posedge aclk); #1; loop = 0; end
      if (p == 1 && v.passes > 1) begin
        @(posedge aclk); #1; start = 1; mode = 2'd0;
        @(posedge aclk); #1; start = 0;
      end
    end
    chk({v.name, " read bursts"}, 32'(ar_log.size()), 32'(16 * v.passes));
    @(negedge aclk);
    chk({v.name, " busy after done"}, 32'(busy), 0);
    chk({v.name, " done pulse"}, 32'(done), 0);
    chk({v.name, " error"}, 32'(error), 32'(v.exp_err));
    chk({v.name, " error_cnt"}, 32'(error_cnt), 32'(v.exp_ecnt));
    chk({v.name, " err_addr"}, 32'(err_addr), 32'(v.exp_eaddr));
    chk({v.name, " pass_cnt"}, 32'(pass_cnt), 32'(v.exp_pcnt));
  endtask

  initial begin
    bit ok;
    vecs[0] = '{"mode0",   2'd0, 1, -1,   -1,   1'b0, 1'b0, 1'b0, 0, 8'h00, 1};
    vecs[1] = '{"walk1",   2'd3, 1, -1,   -1,   1'b0, 1'b0, 1'b0, 0, 8'h00, 1};
    vecs[2] = '{"corrupt", 2'd0, 1, 'h36, -1,   1'b0, 1'b0, 1'b1, 1, 8'h36, 1};
    vecs[3] = '{"droplast",2'd1, 1, -1,   'h30, 1'b0, 1'b0, 1'b1, 1, 8'h3E, 1};
    vecs[4] = '{"hashloop",2'd2, 3, -1,   -1,   1'b0, 1'b0, 1'b0, 0, 8'h00, 3};
    vecs[5] = '{"invstall",2'd1, 1, -1,   -1,   1'b1, 1'b1, 1'b1, 3, 8'h00, 1};

    #12;
    chk("reset awvalid", 32'(awvalid), 0);
    chk("reset busy", 32'(busy), 0);
    chk("reset awlen", 32'(awlen), 7);
    chk("reset arlen", 32'(arlen), 7);
    chk("reset wdata", 32'(wdata), 0);
    @(negedge aclk); aresetn = 1;

    for (int i = 0; i < 6; i++) begin
      run_vec(vecs[i]);
      case (i)
        0: begin
          chk("mode0 aw bursts", 32'(aw_log.size()), 16);
          chk("mode0 awaddr[1]", 32'(aw_log[1]), 32'h10);
          chk("mode0 awaddr[15]", 32'(aw_log[15]), 32'hF0);
          chk("mode0 mem[3]", 32'(mem[3]), 32'h0003);
          chk("mode0 mem[7]", 32'(mem[7]), 32'h0007);
          chk("mode0 wlast position", 32'(wlast_err), 0);
        end
        1: begin
          chk("walk1 mem[0x21]", 32'(mem[8'h21]), 32'h0002);
          chk("walk1 mem[0x2F]", 32'(mem[8'h2F]), 32'h8000);
        end
        3: begin
          chk("droplast araddr[3]", 32'(ar_log[3]), 32'h30);
          chk("droplast araddr[4]", 32'(ar_log[4]), 32'h40);
        end
        4: begin
          chk("hash w0 writes", 32'(w0_log.size()), 3);
          chk("hash pass1 w0", 32'(w0_log[1]), 32'h0001);
          chk("hash pass2 w0", 32'(w0_log[2]), 32'h0002);
          chk("hash pass2 mem[1]", 32'(mem[1]), 32'h79B3);
          chk("hash pass2 mem[2]", 32'(mem[2]), 32'hF360);
        end
        5: begin
          chk("stall stability", 32'(stab_err), 0);
          chk("stall wlast position", 32'(wlast_err), 0);
        end
        default: ;
      endcase
    end

    // asynchronous reset in the middle of a write burst
    corrupt_addr = -1; drop_addr = -1; invert = 0; stall = 0;
    @(posedge aclk); #1; start = 1; mode = 2'd1; loop = 0;
    @(posedge aclk); #1; start = 0;
    ok = 0;
    for (int c = 0; c < 100; c++) begin
      @(negedge aclk);
      if (wvalid) begin ok = 1; break; end
    end
    if (!ok) begin
      n_cmp++; n_fail++;
      $display("FAIL rst: wvalid not seen within 100 cycles");
    end
    repeat (3) @(negedge aclk);
    chk("rst busy before", 32'(busy), 1);
    #2; aresetn = 0;
    #1;
    chk("rst wvalid", 32'(wvalid), 0);
    chk("rst wdata", 32'(wdata), 0);
    chk("rst wlast", 32'(wlast), 0);
    chk("rst busy", 32'(busy), 0);
    chk("rst awaddr", 32'(awaddr), 0);
    chk("rst awlen", 32'(awlen), 7);
    repeat (2) @(posedge aclk);
    @(negedge aclk); aresetn = 1;
    repeat (4) @(negedge aclk);
    chk("rst stays idle", 32'(busy), 0);
    chk("rst no awvalid", 32'(awvalid), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/axi_pattern_test_master.md
# axi_pattern_test_master

Parametrised meta-AXI4 self-test master, next generation of the fixed-pattern self-test master used in the DDR controller benches. It sits on the controller's meta-AXI4 slave port (`aw*`/`w*`/`b*`/`ar*`/`r*`, 8-bit `len`, no size/id). Each pass writes a configurable test region in fixed-length bursts, then reads it back and compares. Adds runtime-selectable data patterns, single-shot or looping passes, a saturating error counter and first-error address capture.

## Interface
- `A_WIDTH`, 25: byte-address width of `awaddr`/`araddr`.
- `A_WIDTH_TEST`, 14: test region is bytes [0, 2^A_WIDTH_TEST); address bits above it are driven 0.
- `D_WIDTH`, 16: data width; must equal 8<<D_LEVEL.
- `D_LEVEL`, 1: log2 of bytes per beat.
- `WBURST_LEN`, 8'd7: `awlen` value. WBURST_LEN+1 must be a power of two, and (WBURST_LEN+1)<<D_LEVEL ≤ 2^A_WIDTH_TEST.
- `RBURST_LEN`, 8'd7: `arlen` value. Same constraints as WBURST_LEN.
- `ECNT_W`, 16: width of `error_cnt`.

Ports:
- `aclk`  in  1  clock.
- `aresetn`  in  1  reset, asynchronous, active-low.
- `start`  in  1  one-cycle pulse; honoured only in IDLE.
- `mode`  in  2  pattern select, sampled when `start` is honoured.
- `loop`  in  1  level; 1 means run passes until `loop` is low at the end of a pass.
- `awvalid`/`awready`/`awaddr`[A_WIDTH]/`awlen`[8]: write address channel.
- `wvalid`/`wready`/`wlast`/`wdata`[D_WIDTH]: write data channel.
- `bvalid`/`bready`: write response channel.
- `arvalid`/`arready`/`araddr`[A_WIDTH]/`arlen`[8]: read address channel.
- `rvalid`/`rready`/`rlast`/`rdata`[D_WIDTH]: read data channel.
- `busy`  out  1  high from the honoured `start` until the final pass completes.
- `done`  out  1  one-cycle pulse at each pass end.
- `pass_cnt`  out  16  completed passes, wraps at 2^16.
- `error`  out  1  sticky; cleared only by `start` or reset.
- `error_cnt`  out  ECNT_W  mismatching beats, saturates at all-ones.
- `err_addr`  out  A_WIDTH  byte address of the first mismatching beat since `start`.

## Operation
- States: IDLE → AW → W → B → (next write burst: AW; region done: AR) → AR → R → (next read burst: AR; region done: PEND) → PEND → (loop: AW; else IDLE).
- Honoured `start`: clears `error`, `error_cnt`, `err_addr` and `pass_cnt`, latches `mode`, burst address = 0.
- Beat byte address = burst base + (beat index << D_LEVEL). Word address w = byte address >> D_LEVEL.
- The 32-bit pattern f(w), given pass count p:
  - mode 0: w.
  - mode 1: ~w.
  - mode 2: (w × 32'h9E3779B1) ^ {16'b0, p}, truncated to 32 bits.
  - mode 3: 32'h1 << w[4:0].
- `wdata` = f replicated across D_WIDTH, truncated from the LSB side.
- Burst base steps by (LEN+1)<<D_LEVEL and wraps to 0 at 2^A_WIDTH_TEST. That wrap ends the phase.
- Read compare happens on `rvalid` && `rready`; a beat errs if `rdata` ≠ the expected pattern.
- A missing `rlast` on beat RBURST_LEN, or an `rlast` on any other beat, counts as one extra error.
- A burst with a missing `rlast` still ends after RBURST_LEN+1 beats.
- The first error captures `err_addr`. Each error increments `error_cnt`, saturating.
- PEND lasts one cycle: `done`=1, `pass_cnt`+1, `loop` sampled.

## Timing
- Reset values: every output 0, except `awlen`=WBURST_LEN and `arlen`=RBURST_LEN (constants). State = IDLE.
- `start` at cycle n → `awvalid`=1 and `busy`=1 at cycle n+1.
- AW: `awvalid` held with stable `awaddr` until `awready`. W begins the next cycle.
- W: `wvalid`=1 for the whole state; beat advances on `wready`. `wlast`=1 exactly on beat WBURST_LEN.
- No AW/W overlap: `wvalid` never rises before the AW handshake.
- B: `bready`=1; leaves on `bvalid`. `bresp` is absent.
- AR is the same as AW. In R, `rready`=1; leaves after beat RBURST_LEN.
- `error`/`error_cnt` update on the cycle after the erring beat.
- `done` coincides with `busy` falling when `loop`=0.
- `start` while busy: ignored.
- Counter and error-count saturation take priority over wrap.
- Async reset mid-burst aborts immediately. The slave must be reset together.

## Structure
- Package `axi_test_pkg`:
  - state enum;
  - mode enum (ADDR, INV, HASH, WALK1);
  - constant 32'h9E3779B1;
  - function `pattern(w, p, mode)` returning 32 bits.
- One combinational sub-module is natural: `axi_test_pattern_gen` (word address, pass, mode → D_WIDTH data). It is instantiated twice, once for the write path and once for the read path.

## Test plan
Common setup: A_WIDTH_TEST=8, D_LEVEL=1, bursts of 7, ideal slave memory.
- mode 0, loop=0 → `awaddr` 0x00,0x10…0xF0. First burst `wdata` 0…7, `wlast` on the 8th beat. `done` after the 16th read burst; `error`=0, `pass_cnt`=1.
- mode 3 → beat at byte 0x42 (w=0x21) writes 16'h0002. Read matches.
- Slave corrupts the read at byte 0x36 → `error`=1, `error_cnt`=1, `err_addr`=0x36.
- Slave drops `rlast` on one burst → `error_cnt`=1, and the next `araddr` still advances by 0x10.
- mode 2, loop=1 for 3 passes, then loop=0 → `pass_cnt`=3, and the second pass `wdata` at w=0 is 16'h0001.
- Random `awready`/`wready`/`rvalid` stalls, `ECNT_W`=2, slave inverts all data → `error_cnt`=3 (saturated), data stable under stalls. Separately, an async reset mid-W → all outputs 0 in the same cycle.
